// File: rtl/ysyx_23060096_imem.sv
// Instruction memory responder for the NPC fetch port: valid/ready request, fixed LAT, held response.
// Range and alignment checking is compiled in only when YSYX_23060096_IMEM_ERR_EN is defined.
module ysyx_23060096_imem #(
  parameter int          DEPTH = 1024,
  parameter logic [31:0] BASE  = 32'h8000_0000,
  parameter int          LAT   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_inst,
  output logic                     rsp_err,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_idx,
  input  logic [31:0]              ld_data
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [31:0] addr_q, addr_nx;
  logic [31:0] inst_q, inst_nx;
  logic        err_q, err_nx;

  logic [31:0] mem [DEPTH];
  logic [31:0] off;
  logic [AW-1:0] idx;
  logic        bad;
  logic        unused_off_bits;

  assign off = addr_q - BASE;
  assign idx = off[AW+1:2];
  assign unused_off_bits = ^{off[31:AW+2], off[1:0]};

`ifdef YSYX_23060096_IMEM_ERR_EN
  assign bad = (addr_q < BASE) || (off >= 32'(DEPTH) * 32'd4) || (addr_q[1:0] != 2'b00);
`else
  // Without checking, the index wraps modulo DEPTH and the byte offset is dropped.
  assign bad = 1'b0;
`endif

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_inst  = inst_q;
  assign rsp_err   = err_q;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    addr_nx  = addr_q;
    inst_nx  = inst_q;
    err_nx   = err_q;
    case (state)
      IDLE: begin
        if (req_valid) begin
          addr_nx  = req_addr;
          cnt_nx   = 4'(LAT - 1);
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          inst_nx  = bad ? 32'h0000_0000 : mem[idx];
          err_nx   = bad;
          state_nx = RESP;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      addr_q <= 32'h0000_0000;
      inst_q <= 32'h0000_0000;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      addr_q <= addr_nx;
      inst_q <= inst_nx;
      err_q  <= err_nx;
    end
  end

  // Array is not reset; the capture above sees the pre-edge contents, giving read-before-write.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_data;
  end
endmodule
